// File: rtl/fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_pkg
// Brief    : Shared state encoding and PC constants for the fetch sequencer.
// Revision : 1.0
// ============================================================================
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALT     = 3'd4,
        ST_ERR      = 3'd5
    } fetch_state_e;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_VECTOR = 32'd0;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_wait_timer
// Brief    : Loadable up-counter; o_tc flags the last count before LIMIT.
// Revision : 1.0
// ============================================================================
module fetch_seq_wait_timer #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // High when the cycle being counted now is the LIMIT-th one.
    assign o_tc = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Fetch-stage controller: boot, fetch, wait, redirect, halt, error.
//            Performance counters are built only with FETCH_SEQ_PERF_EN.
// Revision : 1.0
// ============================================================================
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int WAIT_MAX    = 15,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              halt_req,
    input  logic              imem_ready,
    output logic              pc_clear,
    output logic              pc_sel,
    output logic [31:0]       jump_addr,
    output logic              imem_rd,
    output logic              if_valid,
    output logic              if_flush,
    output logic              halted,
    output logic              timeout_err
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_fetch_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

    localparam int c_boot_w = $clog2(BOOT_CYCLES + 1);
    localparam int c_wait_w = $clog2(WAIT_MAX + 1);

    if (BOOT_CYCLES < 1 || WAIT_MAX < 1 || CNT_W < 1) begin : g_param_check
        $error("fetch_sequencer: BOOT_CYCLES, WAIT_MAX and CNT_W must be >= 1");
    end

    fetch_state_e r_state;
    logic [31:0]  r_shadow;

    logic        w_run;
    logic        w_boot_en;
    logic        w_boot_tc;
    logic        w_wait_en;
    logic        w_wait_tc;
    logic [31:0] w_target;

    assign w_run     = (r_state == ST_FETCH) || (r_state == ST_WAIT);
    assign w_boot_en = (r_state == ST_BOOT);
    assign w_target  = align_pc(branch_target);

    // The timer advances only on a plain memory miss; any other outcome restarts it.
    assign w_wait_en = w_run & ~branch_taken & ~halt_req & ~stall & ~imem_ready & ~w_wait_tc;

    fetch_seq_wait_timer #(
        .WIDTH (c_boot_w),
        .LIMIT (BOOT_CYCLES)
    ) u_boot_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_boot_en),
        .o_tc       (w_boot_tc)
    );

    fetch_seq_wait_timer #(
        .WIDTH (c_wait_w),
        .LIMIT (WAIT_MAX)
    ) u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (~w_wait_en),
        .i_load_val ('0),
        .i_en       (w_wait_en),
        .o_tc       (w_wait_tc)
    );

    // Holding the PC means reloading the shadow PC through the jump path,
    // because the datapath PC register loads on every negedge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_shadow    <= RESET_VECTOR;
            pc_clear    <= 1'b1;
            pc_sel      <= 1'b0;
            jump_addr   <= RESET_VECTOR;
            imem_rd     <= 1'b0;
            if_valid    <= 1'b0;
            if_flush    <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pc_clear  <= 1'b0;
            pc_sel    <= 1'b0;
            jump_addr <= r_shadow;
            imem_rd   <= 1'b0;
            if_valid  <= 1'b0;
            if_flush  <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    pc_clear  <= 1'b1;
                    jump_addr <= RESET_VECTOR;
                    if (w_boot_tc) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH, ST_WAIT: begin
                    if (branch_taken) begin
                        imem_rd   <= 1'b1;
                        jump_addr <= w_target;
                        r_shadow  <= w_target;
                        if_flush  <= 1'b1;
                        r_state   <= ST_REDIRECT;
                    end else if (halt_req) begin
                        halted  <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (stall) begin
                        imem_rd <= 1'b1;
                    end else if (imem_ready) begin
                        imem_rd  <= 1'b1;
                        pc_sel   <= 1'b1;
                        if_valid <= 1'b1;
                        r_shadow <= r_shadow + PC_STEP;
                        r_state  <= ST_FETCH;
                    end else if (w_wait_tc) begin
                        timeout_err <= 1'b1;
                        r_state     <= ST_ERR;
                    end else begin
                        imem_rd <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_REDIRECT: begin
                    imem_rd <= 1'b1;
                    if (branch_taken) begin
                        jump_addr <= w_target;
                        r_shadow  <= w_target;
                        if_flush  <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT, ST_ERR: begin
                    imem_rd <= 1'b0;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic w_fetch_hit;

    assign w_fetch_hit = w_run & ~branch_taken & ~halt_req & ~stall & imem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (w_run) begin
            if (w_fetch_hit) begin
                if (~&perf_fetch_cnt) begin
                    perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(1);
                end
            end else if (~&perf_stall_cnt) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed and random stimulus against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

    localparam int BOOT_CYCLES = 2;
    localparam int WAIT_MAX    = 15;
    localparam int CNT_W       = 32;

    localparam int MODE_RUN   = 0;
    localparam int MODE_REDIR = 1;
    localparam int MODE_HALT  = 2;
    localparam int MODE_ERR   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        halt_req = 1'b0;
    logic        imem_ready = 1'b0;
    logic        pc_clear;
    logic        pc_sel;
    logic [31:0] jump_addr;
    logic        imem_rd;
    logic        if_valid;
    logic        if_flush;
    logic        halted;
    logic        timeout_err;
`ifdef FETCH_SEQ_PERF_EN
    logic [CNT_W-1:0] perf_fetch_cnt;
    logic [CNT_W-1:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .WAIT_MAX    (WAIT_MAX),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .imem_ready    (imem_ready),
        .pc_clear      (pc_clear),
        .pc_sel        (pc_sel),
        .jump_addr     (jump_addr),
        .imem_rd       (imem_rd),
        .if_valid      (if_valid),
        .if_flush      (if_flush),
        .halted        (halted),
        .timeout_err   (timeout_err)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: boot countdown, coarse mode, shadow PC, miss run length.
    int          m_boot_left;
    int          m_mode;
    logic [31:0] m_shadow;
    int          m_miss;
    bit          m_halted;
    bit          m_err;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    bit          e_clear, e_sel, e_rd, e_valid, e_flush, e_jchk;
    logic [31:0] e_jump;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_redirect(input logic [31:0] tgt);
        m_shadow = tgt & 32'hFFFF_FFFC;
        e_jump   = m_shadow;
        e_flush  = 1'b1;
        e_rd     = 1'b1;
        m_mode   = MODE_REDIR;
        m_miss   = 0;
    endtask

    task automatic model_step(input bit rn, input bit st, input bit br,
                              input logic [31:0] tgt, input bit hr, input bit rdy);
        e_clear = 1'b0; e_sel = 1'b0; e_rd = 1'b0; e_valid = 1'b0; e_flush = 1'b0;
        e_jchk  = 1'b1; e_jump = m_shadow;
        if (!rn) begin
            m_boot_left = BOOT_CYCLES; m_shadow = 32'd0; m_mode = MODE_RUN; m_miss = 0;
            m_halted = 1'b0; m_err = 1'b0; m_fetch = 32'd0; m_stall = 32'd0;
            e_clear = 1'b1; e_jump = 32'd0;
        end else if (m_boot_left > 0) begin
            m_boot_left--;
            e_clear = 1'b1; e_jump = 32'd0;
        end else if (m_mode == MODE_RUN) begin
            if (br) begin
                model_redirect(tgt);
                m_stall++;
            end else if (hr) begin
                m_mode = MODE_HALT; m_halted = 1'b1; m_stall++;
            end else if (st) begin
                e_rd = 1'b1; m_miss = 0; m_stall++;
            end else if (rdy) begin
                e_rd = 1'b1; e_sel = 1'b1; e_valid = 1'b1; e_jchk = 1'b0;
                m_shadow = m_shadow + 32'd4; m_miss = 0; m_fetch++;
            end else begin
                m_miss++; m_stall++;
                if (m_miss >= WAIT_MAX) begin
                    m_mode = MODE_ERR; m_err = 1'b1;
                end else begin
                    e_rd = 1'b1;
                end
            end
        end else if (m_mode == MODE_REDIR) begin
            if (br) begin
                model_redirect(tgt);
            end else begin
                e_rd = 1'b1; m_mode = MODE_RUN;
            end
        end
    endtask

    task automatic tick(input bit rn, input bit st, input bit br,
                        input logic [31:0] tgt, input bit hr, input bit rdy);
        rst_n = rn; stall = st; branch_taken = br; branch_target = tgt;
        halt_req = hr; imem_ready = rdy;
        model_step(rn, st, br, tgt, hr, rdy);
        @(posedge clk);
        #1;
        check_eq("flags", {25'd0, pc_clear, pc_sel, imem_rd, if_valid, if_flush, halted, timeout_err},
                 {25'd0, e_clear, e_sel, e_rd, e_valid, e_flush, m_halted, m_err});
        if (e_jchk) check_eq("jump_addr", jump_addr, e_jump);
`ifdef FETCH_SEQ_PERF_EN
        check_eq("perf_fetch", perf_fetch_cnt, m_fetch);
        check_eq("perf_stall", perf_stall_cnt, m_stall);
`endif
    endtask

    initial begin
        // Reset, boot, steady fetch with memory always ready
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        check_eq("reset_clear", {31'd0, pc_clear}, 32'd1);
        for (int i = 0; i < BOOT_CYCLES + 4; i++) tick(1, 0, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 1);
        check_eq("pc_after_4", jump_addr, 32'd16);

        // Three memory wait cycles, then resume
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 1);

        // Branch to an unaligned target while stalled
        tick(1, 1, 1, 32'h103, 0, 1);
        check_eq("branch_jump", jump_addr, 32'h100);
        check_eq("branch_flush", {31'd0, if_flush}, 32'd1);
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        check_eq("valid_at_target", {31'd0, if_valid}, 32'd1);
        tick(1, 1, 0, 0, 0, 1);
        check_eq("pc_after_target", jump_addr, 32'h104);

        // Memory timeout and sticky error, cleared by reset
        for (int i = 0; i < WAIT_MAX; i++) tick(1, 0, 0, 0, 0, 0);
        check_eq("timeout_set", {31'd0, timeout_err}, 32'd1);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 1);
        check_eq("timeout_sticky_rd", {31'd0, imem_rd}, 32'd0);
        tick(0, 0, 0, 0, 0, 1);
        check_eq("timeout_cleared", {31'd0, timeout_err}, 32'd0);
        for (int i = 0; i < BOOT_CYCLES; i++) tick(1, 0, 0, 0, 0, 1);

        // Branch beats halt; then a lone halt freezes everything
        tick(1, 0, 1, 32'h40, 1, 1);
        check_eq("branch_over_halt", {30'd0, halted, if_flush}, 32'd1);
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0, 1);
        check_eq("halt_frozen_pc", jump_addr, 32'h44);
        check_eq("halt_flags", {30'd0, halted, imem_rd}, 32'd2);

        // Shadow PC wraps at the top of the address space
        tick(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < BOOT_CYCLES; i++) tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 1, 32'hFFFF_FFFF, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 1);
        check_eq("pc_wrap", jump_addr, 32'd0);

        // Random traffic with occasional resets to escape halt/error
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 199) != 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
